apb_regfile_slave: RTL and testbench

APB_REGFILE_SLAVE -- requirements
Module: apb_regfile_slave

---
 rtl/apb_regfile_slave.sv | 131 +++++++++++++
 tb/tb_apb_regfile_slave.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_regfile_slave.sv
// APB register-file slave: DEPTH words with byte strobes, optional wait
// states, and registered pready/prdata/pslverr.
module apb_regfile_slave #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                pclk,
    input  logic                presetn,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [ADDR_W-1:0]   paddr,
    input  logic [DATA_W-1:0]   pwdata,
    input  logic [DATA_W/8-1:0] pstrb,
    output logic                pready,
    output logic [DATA_W-1:0]   prdata,
    output logic                pslverr
);
    localparam int NB = DATA_W / 8;
    localparam int LB = $clog2(NB);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] LMASK = ADDR_W'((1 << LB) - 1);
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, READY} state_t;

    state_t            state, state_nx;
    logic [3:0]        cnt, cnt_nx;
    logic [ADDR_W-1:0] cap_addr;
    logic              cap_write;
    logic [DATA_W-1:0] cap_wdata;
    logic [NB-1:0]     cap_strb;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              setup;
    logic              load;
    logic              commit;
    logic [ADDR_W-1:0] src_addr;
    logic              src_write;

    // Out-of-range words and sub-word byte offsets both raise pslverr.
    function automatic logic addr_err(input logic [ADDR_W-1:0] a);
        logic [ADDR_W:0] idx;
        idx = {1'b0, a} >> LB;
        return (idx >= DEPTH_V) || ((a & LMASK) != '0);
    endfunction

    function automatic logic [IW-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return IW'(a >> LB);
    endfunction

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        setup    = 1'b0;
        unique case (state)
            IDLE: begin
                if (psel && !penable) begin
                    setup = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_nx = READY;
                    end else begin
                        state_nx = WAIT;
                        cnt_nx   = 4'(WAIT_CYCLES);
                    end
                end
            end
            WAIT: begin
                if (!psel) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (cnt == 4'd1) begin
                    state_nx = READY;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            READY:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // With no wait states the response is built from the live setup signals.
    assign src_addr  = setup ? paddr : cap_addr;
    assign src_write = setup ? pwrite : cap_write;
    assign load      = (state_nx == READY);
    assign commit    = (state == READY) && psel && penable &&
                       cap_write && !addr_err(cap_addr);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state     <= IDLE;
            cnt       <= '0;
            cap_addr  <= '0;
            cap_write <= 1'b0;
            cap_wdata <= '0;
            cap_strb  <= '0;
            pready    <= 1'b0;
            prdata    <= '0;
            pslverr   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            pready  <= load;
            pslverr <= load && addr_err(src_addr);
            if (load) begin
                prdata <= (!src_write && !addr_err(src_addr)) ?
                          mem[word_idx(src_addr)] : '0;
            end
            if (setup) begin
                cap_addr  <= paddr;
                cap_write <= pwrite;
                cap_wdata <= pwdata;
                cap_strb  <= pstrb;
            end
            if (commit) begin
                for (int b = 0; b < NB; b++) begin
                    if (cap_strb[b]) begin
                        mem[word_idx(cap_addr)][8*b +: 8] <= cap_wdata[8*b +: 8];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_apb_regfile_slave.sv
// Bench for apb_regfile_slave: three instances (defaults, DEPTH=32,
// WAIT_CYCLES=3) driven by APB tasks with an expected-response queue.
module tb_apb_regfile_slave;
    localparam int N = 3;

    logic        pclk = 1'b0;
    logic        presetn;
    logic        psel    [N];
    logic        penable [N];
    logic        pwrite  [N];
    logic [7:0]  paddr   [N];
    logic [31:0] pwdata  [N];
    logic [3:0]  pstrb   [N];
    logic        pready  [N];
    logic [31:0] prdata  [N];
    logic        pslverr [N];

    typedef struct {
        int          k;
        logic [31:0] data;
        logic        err;
        int          cyc;
    } txn_t;

    txn_t sb[$];
    txn_t ob[$];

    int n_chk  = 0;
    int n_fail = 0;

    logic        su_rdy;
    logic        su_err;
    logic [31:0] su_data;

    always #5 pclk = ~pclk;

    apb_regfile_slave #(.DATA_W(32), .ADDR_W(8), .DEPTH(64), .WAIT_CYCLES(0)) u0 (
        .pclk(pclk), .presetn(presetn), .psel(psel[0]), .penable(penable[0]),
        .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]), .pstrb(pstrb[0]),
        .pready(pready[0]), .prdata(prdata[0]), .pslverr(pslverr[0])
    );

    apb_regfile_slave #(.DATA_W(32), .ADDR_W(8), .DEPTH(32), .WAIT_CYCLES(0)) u1 (
        .pclk(pclk), .presetn(presetn), .psel(psel[1]), .penable(penable[1]),
        .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]), .pstrb(pstrb[1]),
        .pready(pready[1]), .prdata(prdata[1]), .pslverr(pslverr[1])
    );

    apb_regfile_slave #(.DATA_W(32), .ADDR_W(8), .DEPTH(64), .WAIT_CYCLES(3)) u2 (
        .pclk(pclk), .presetn(presetn), .psel(psel[2]), .penable(penable[2]),
        .pwrite(pwrite[2]), .paddr(paddr[2]), .pwdata(pwdata[2]), .pstrb(pstrb[2]),
        .pready(pready[2]), .prdata(prdata[2]), .pslverr(pslverr[2])
    );

    // Setup then access; returns after sampling the pready cycle, leaving
    // psel/penable high so a following call runs back-to-back.
    task automatic xfer(input int k, input logic wr, input logic [7:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        input bit scr);
        txn_t o;
        int   c;
        @(posedge pclk); #1;
        psel[k]    = 1'b1;
        penable[k] = 1'b0;
        pwrite[k]  = wr;
        paddr[k]   = a;
        pwdata[k]  = d;
        pstrb[k]   = s;
        @(negedge pclk);
        su_rdy  = pready[k];
        su_err  = pslverr[k];
        su_data = prdata[k];
        @(posedge pclk); #1;
        penable[k] = 1'b1;
        if (scr) begin
            paddr[k]  = a ^ 8'h04;
            pwdata[k] = ~d;
        end
        c = 1;
        @(negedge pclk);
        while (pready[k] !== 1'b1 && c < 40) begin
            @(posedge pclk); #1;
            c++;
            @(negedge pclk);
        end
        o.k    = k;
        o.data = prdata[k];
        o.err  = pslverr[k];
        o.cyc  = (pready[k] === 1'b1) ? c : -1;
        ob.push_back(o);
    endtask

    task automatic bus_idle(input int k);
        @(posedge pclk); #1;
        psel[k]    = 1'b0;
        penable[k] = 1'b0;
    endtask

    task automatic test_reset;
        presetn = 1'b1;
        for (int k = 0; k < N; k++) begin
            psel[k] = 1'b0; penable[k] = 1'b0; pwrite[k] = 1'b0;
            paddr[k] = '0; pwdata[k] = '0; pstrb[k] = '0;
        end
        #3 presetn = 1'b0;
        #10;
        for (int k = 0; k < N; k++) begin
            n_chk++;
            if (pready[k] !== 1'b0 || prdata[k] !== 32'h0 || pslverr[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state k%0d: got rdy=%b data=%h err=%b, expected 0/0/0",
                         k, pready[k], prdata[k], pslverr[k]);
            end
        end
        @(negedge pclk);
        presetn = 1'b1;
    endtask

    task automatic test_basic;
        txn_t e, o;
        sb.push_back('{0, 32'h0, 1'b0, 1});
        xfer(0, 1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 1'b0);
        sb.push_back('{0, 32'hDEADBEEF, 1'b0, 1});
        xfer(0, 1'b0, 8'h10, 32'h0, 4'hF, 1'b0);
        bus_idle(0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            n_chk++;
            if (ob.size() == 0) begin
                n_fail++;
                $display("FAIL basic: no response, expected data=%h", e.data);
            end else begin
                o = ob.pop_front();
                if (o.k != e.k || o.data !== e.data || o.err !== e.err || o.cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL basic: got k%0d data=%h err=%b cyc=%0d, expected k%0d data=%h err=%b cyc=%0d",
                             o.k, o.data, o.err, o.cyc, e.k, e.data, e.err, e.cyc);
                end
            end
        end
    endtask

    task automatic test_strobe;
        txn_t e, o;
        sb.push_back('{0, 32'h0, 1'b0, 1});
        xfer(0, 1'b1, 8'h10, 32'h11223344, 4'h5, 1'b0);
        sb.push_back('{0, 32'hDE22BE44, 1'b0, 1});
        xfer(0, 1'b0, 8'h10, 32'h0, 4'hF, 1'b0);
        sb.push_back('{0, 32'h0, 1'b0, 1});
        xfer(0, 1'b1, 8'h10, 32'hFFFFFFFF, 4'h0, 1'b0);
        sb.push_back('{0, 32'hDE22BE44, 1'b0, 1});
        xfer(0, 1'b0, 8'h10, 32'h0, 4'h0, 1'b0);
        sb.push_back('{0, 32'h0, 1'b0, 1});
        xfer(0, 1'b1, 8'h14, 32'hA1B2C3D4, 4'hA, 1'b0);
        sb.push_back('{0, 32'hA100C300, 1'b0, 1});
        xfer(0, 1'b0, 8'h14, 32'h0, 4'h3, 1'b0);
        bus_idle(0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            n_chk++;
            if (ob.size() == 0) begin
                n_fail++;
                $display("FAIL strobe: no response, expected data=%h", e.data);
            end else begin
                o = ob.pop_front();
                if (o.k != e.k || o.data !== e.data || o.err !== e.err || o.cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL strobe: got data=%h err=%b cyc=%0d, expected data=%h err=%b cyc=%0d",
                             o.data, o.err, o.cyc, e.data, e.err, e.cyc);
                end
            end
        end
    endtask

    task automatic test_errors;
        txn_t e, o;
        sb.push_back('{0, 32'hDE22BE44, 1'b0, 1});
        xfer(0, 1'b0, 8'h10, 32'h0, 4'hF, 1'b0);
        sb.push_back('{0, 32'h0, 1'b1, 1});
        xfer(0, 1'b0, 8'h02, 32'h0, 4'hF, 1'b0);
        sb.push_back('{0, 32'h0, 1'b0, 1});
        xfer(0, 1'b1, 8'hFC, 32'hCAFEF00D, 4'hF, 1'b0);
        sb.push_back('{0, 32'hCAFEF00D, 1'b0, 1});
        xfer(0, 1'b0, 8'hFC, 32'h0, 4'hF, 1'b0);
        sb.push_back('{0, 32'h0, 1'b1, 1});
        xfer(0, 1'b1, 8'h11, 32'h99999999, 4'hF, 1'b0);
        sb.push_back('{0, 32'hDE22BE44, 1'b0, 1});
        xfer(0, 1'b0, 8'h10, 32'h0, 4'hF, 1'b0);
        bus_idle(0);
        sb.push_back('{1, 32'h0, 1'b0, 1});
        xfer(1, 1'b1, 8'h7C, 32'h55AA55AA, 4'hF, 1'b0);
        sb.push_back('{1, 32'h0, 1'b1, 1});
        xfer(1, 1'b1, 8'h80, 32'h77777777, 4'hF, 1'b0);
        sb.push_back('{1, 32'h55AA55AA, 1'b0, 1});
        xfer(1, 1'b0, 8'h7C, 32'h0, 4'hF, 1'b0);
        sb.push_back('{1, 32'h0, 1'b1, 1});
        xfer(1, 1'b0, 8'h80, 32'h0, 4'hF, 1'b0);
        sb.push_back('{1, 32'h0, 1'b0, 1});
        xfer(1, 1'b0, 8'h00, 32'h0, 4'hF, 1'b0);
        bus_idle(1);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            n_chk++;
            if (ob.size() == 0) begin
                n_fail++;
                $display("FAIL errors: no response, expected data=%h err=%b", e.data, e.err);
            end else begin
                o = ob.pop_front();
                if (o.k != e.k || o.data !== e.data || o.err !== e.err || o.cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL errors: got k%0d data=%h err=%b cyc=%0d, expected k%0d data=%h err=%b cyc=%0d",
                             o.k, o.data, o.err, o.cyc, e.k, e.data, e.err, e.cyc);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        txn_t e, o;
        sb.push_back('{0, 32'h0, 1'b0, 1});
        xfer(0, 1'b1, 8'h20, 32'h0BADF00D, 4'hF, 1'b0);
        sb.push_back('{0, 32'h0BADF00D, 1'b0, 1});
        xfer(0, 1'b0, 8'h20, 32'h0, 4'hF, 1'b0);
        sb.push_back('{0, 32'h0, 1'b1, 1});
        xfer(0, 1'b0, 8'h02, 32'h0, 4'hF, 1'b0);
        n_chk++;
        if (su_rdy !== 1'b0 || su_data !== 32'h0BADF00D || su_err !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_hold: got rdy=%b data=%h err=%b, expected 0/0badf00d/0",
                     su_rdy, su_data, su_err);
        end
        sb.push_back('{0, 32'h0BADF00D, 1'b0, 1});
        xfer(0, 1'b0, 8'h20, 32'h0, 4'hF, 1'b0);
        n_chk++;
        if (su_rdy !== 1'b0 || su_err !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_err_clear: got rdy=%b err=%b, expected 0/0", su_rdy, su_err);
        end
        bus_idle(0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            n_chk++;
            if (ob.size() == 0) begin
                n_fail++;
                $display("FAIL b2b: no response, expected data=%h", e.data);
            end else begin
                o = ob.pop_front();
                if (o.k != e.k || o.data !== e.data || o.err !== e.err || o.cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL b2b: got data=%h err=%b cyc=%0d, expected data=%h err=%b cyc=%0d",
                             o.data, o.err, o.cyc, e.data, e.err, e.cyc);
                end
            end
        end
    endtask

    task automatic test_protocol;
        txn_t e, o;
        int   hits;
        hits = 0;
        @(posedge pclk); #1;
        psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1;
        paddr[0] = 8'h10; pwdata[0] = 32'h0; pstrb[0] = 4'hF;
        repeat (4) begin
            @(negedge pclk);
            if (pready[0] !== 1'b0) hits++;
        end
        bus_idle(0);
        n_chk++;
        if (hits != 0) begin
            n_fail++;
            $display("FAIL protocol_violation: got %0d pready cycles, expected 0", hits);
        end
        sb.push_back('{0, 32'hDE22BE44, 1'b0, 1});
        xfer(0, 1'b0, 8'h10, 32'h0, 4'hF, 1'b0);
        sb.push_back('{0, 32'h0, 1'b0, 1});
        xfer(0, 1'b1, 8'h30, 32'h13579BDF, 4'hF, 1'b1);
        sb.push_back('{0, 32'h13579BDF, 1'b0, 1});
        xfer(0, 1'b0, 8'h30, 32'h0, 4'hF, 1'b0);
        sb.push_back('{0, 32'h0, 1'b0, 1});
        xfer(0, 1'b0, 8'h34, 32'h0, 4'hF, 1'b0);
        bus_idle(0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            n_chk++;
            if (ob.size() == 0) begin
                n_fail++;
                $display("FAIL capture: no response, expected data=%h", e.data);
            end else begin
                o = ob.pop_front();
                if (o.k != e.k || o.data !== e.data || o.err !== e.err || o.cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL capture: got data=%h err=%b cyc=%0d, expected data=%h err=%b cyc=%0d",
                             o.data, o.err, o.cyc, e.data, e.err, e.cyc);
                end
            end
        end
    endtask

    task automatic test_wait_abort;
        txn_t e, o;
        int   hits;
        sb.push_back('{2, 32'h0, 1'b0, 4});
        xfer(2, 1'b1, 8'h08, 32'h12345678, 4'hF, 1'b0);
        sb.push_back('{2, 32'h12345678, 1'b0, 4});
        xfer(2, 1'b0, 8'h08, 32'h0, 4'hF, 1'b0);
        bus_idle(2);
        hits = 0;
        @(posedge pclk); #1;
        psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1;
        paddr[2] = 8'h04; pwdata[2] = 32'hA5A5A5A5; pstrb[2] = 4'hF;
        @(posedge pclk); #1;
        penable[2] = 1'b1;
        @(negedge pclk);
        if (pready[2] !== 1'b0) hits++;
        @(posedge pclk); #1;
        psel[2] = 1'b0; penable[2] = 1'b0;
        repeat (8) begin
            @(negedge pclk);
            if (pready[2] !== 1'b0 || pslverr[2] !== 1'b0) hits++;
        end
        n_chk++;
        if (hits != 0) begin
            n_fail++;
            $display("FAIL abort_pready: got %0d ready/err cycles, expected 0", hits);
        end
        sb.push_back('{2, 32'h0, 1'b0, 4});
        xfer(2, 1'b0, 8'h04, 32'h0, 4'hF, 1'b0);
        bus_idle(2);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            n_chk++;
            if (ob.size() == 0) begin
                n_fail++;
                $display("FAIL wait: no response, expected data=%h", e.data);
            end else begin
                o = ob.pop_front();
                if (o.k != e.k || o.data !== e.data || o.err !== e.err || o.cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL wait: got data=%h err=%b cyc=%0d, expected data=%h err=%b cyc=%0d",
                             o.data, o.err, o.cyc, e.data, e.err, e.cyc);
                end
            end
        end
    endtask

    task automatic test_reset_midway;
        txn_t e, o;
        sb.push_back('{2, 32'h12345678, 1'b0, 4});
        xfer(2, 1'b0, 8'h08, 32'h0, 4'hF, 1'b0);
        bus_idle(2);
        @(posedge pclk); #1;
        psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1;
        paddr[2] = 8'h08; pwdata[2] = 32'hFFFFFFFF; pstrb[2] = 4'hF;
        @(posedge pclk); #1;
        penable[2] = 1'b1;
        @(negedge pclk);
        #2 presetn = 1'b0;
        #1;
        n_chk++;
        if (pready[2] !== 1'b0 || prdata[2] !== 32'h0 || pslverr[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got rdy=%b data=%h err=%b, expected 0/0/0",
                     pready[2], prdata[2], pslverr[2]);
        end
        psel[2] = 1'b0; penable[2] = 1'b0;
        @(negedge pclk);
        presetn = 1'b1;
        sb.push_back('{2, 32'h0, 1'b0, 4});
        xfer(2, 1'b0, 8'h08, 32'h0, 4'hF, 1'b0);
        bus_idle(2);
        sb.push_back('{0, 32'h0, 1'b0, 1});
        xfer(0, 1'b0, 8'h10, 32'h0, 4'hF, 1'b0);
        sb.push_back('{0, 32'h0, 1'b0, 1});
        xfer(0, 1'b0, 8'hFC, 32'h0, 4'hF, 1'b0);
        bus_idle(0);
        sb.push_back('{1, 32'h0, 1'b0, 1});
        xfer(1, 1'b0, 8'h7C, 32'h0, 4'hF, 1'b0);
        bus_idle(1);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            n_chk++;
            if (ob.size() == 0) begin
                n_fail++;
                $display("FAIL reset_mid: no response, expected data=%h", e.data);
            end else begin
                o = ob.pop_front();
                if (o.k != e.k || o.data !== e.data || o.err !== e.err || o.cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL reset_mid: got k%0d data=%h err=%b cyc=%0d, expected k%0d data=%h err=%b cyc=%0d",
                             o.k, o.data, o.err, o.cyc, e.k, e.data, e.err, e.cyc);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_strobe();
        test_errors();
        test_back_to_back();
        test_protocol();
        test_wait_abort();
        test_reset_midway();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
